// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter funnelling per-core icache/dcache traffic onto one RAM port
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [CPUS-1:0]              iREN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  iaddr,
  input  logic [CPUS-1:0]              dREN,
  input  logic [CPUS-1:0]              dWEN,
  input  logic [CPUS-1:0][ADDR_W-1:0]  daddr,
  input  logic [CPUS-1:0][DATA_W-1:0]  dstore,
  output logic [CPUS-1:0]              iwait,
  output logic [CPUS-1:0]              dwait,
  output logic [CPUS-1:0][DATA_W-1:0]  iload,
  output logic [CPUS-1:0][DATA_W-1:0]  dload,
  output logic                         ramREN,
  output logic                         ramWEN,
  output logic [ADDR_W-1:0]            ramaddr,
  output logic [DATA_W-1:0]            ramstore,
  input  logic [DATA_W-1:0]            ramload,
  input  logic [1:0]                   ramstate
);

  localparam int PTR_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gcore;     // granted core
  logic             gtype;     // granted type: 1 = D, 0 = I
  logic [PTR_W-1:0] arb_core;
  logic             arb_type;
  logic             arb_valid;
  logic [CPUS-1:0]  dreq;
  logic             greq;
  logic             done;
  logic [PTR_W:0]   ptr_sum;
  logic [PTR_W-1:0] ptr_inc;

  // A write wins when both dREN and dWEN are set, so D qualification is just the OR.
  assign dreq = dREN | dWEN;

  // Live request of the granted source; dropping it before ACCESS aborts the grant.
  assign greq = gtype ? dreq[gcore] : iREN[gcore];
  assign done = (state == SERVE) && greq && (ramstate == RS_ACCESS);

  // Pointer moves past the served core so each core is served at most once per round.
  assign ptr_sum = {1'b0, gcore} + (PTR_W+1)'(1);
  assign ptr_inc = (ptr_sum >= (PTR_W+1)'(CPUS)) ? '0 : ptr_sum[PTR_W-1:0];

  // Round-robin scan from rr_ptr; within a core the D source beats the I source.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    arb_valid = 1'b0;
    arb_core  = '0;
    arb_type  = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < CPUS; i++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(CPUS)) sum = sum - (PTR_W+1)'(CPUS);
      idx = sum[PTR_W-1:0];
      if (!arb_valid && (dreq[idx] || iREN[idx])) begin
        arb_valid = 1'b1;
        arb_core  = idx;
        arb_type  = dreq[idx];
      end
    end
  end

  // State register, grant capture and round-robin pointer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gcore  <= '0;
      gtype  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && arb_valid) begin
        gcore <= arb_core;
        gtype <= arb_type;
      end
      if (done) rr_ptr <= ptr_inc;
    end
  end

  // Next state: grant from IDLE, leave SERVE on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = SERVE;
      SERVE:   if (!greq || done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: RAM port follows the granted source's live inputs; one-cycle wait-low on completion.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state == SERVE) begin
      if (gtype) begin
        ramaddr  = daddr[gcore];
        ramstore = dstore[gcore];
        ramWEN   = dWEN[gcore];
        ramREN   = dREN[gcore] & ~dWEN[gcore];
      end else begin
        ramaddr  = iaddr[gcore];
        ramREN   = iREN[gcore];
      end
      if (done) begin
        if (gtype) begin
          dwait[gcore] = 1'b0;
          if (!dWEN[gcore]) dload[gcore] = ramload;
        end else begin
          iwait[gcore] = 1'b0;
          iload[gcore] = ramload;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [CPUS-1:0]       iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic                  ramREN, ramWEN;
  logic [31:0]           ramaddr, ramstore, ramload;
  logic [1:0]            ramstate;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.CPUS(CPUS), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({iwait, dwait} !== 4'b1111) begin
      failures++; $display("FAIL reset_waits: got %b expected 1111", {iwait, dwait});
    end
    checks++;
    if ({ramREN, ramWEN, ramaddr, ramstore} !== 66'd0) begin
      failures++; $display("FAIL reset_ram: got %b %b %h %h expected 0 0 0 0", ramREN, ramWEN, ramaddr, ramstore);
    end
    checks++;
    if ({iload, dload} !== 128'd0) begin
      failures++; $display("FAIL reset_loads: got %h expected 0", {iload, dload});
    end
    checks++;
    if (dut.rr_ptr !== 1'b0) begin
      failures++; $display("FAIL reset_rr_ptr: got %0d expected 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single_fetch();
    iREN[0] = 1'b1; iaddr[0] = 32'h40; ramstate = BUSY;
    #1;
    checks++;
    if (ramREN !== 1'b0) begin
      failures++; $display("FAIL fetch_idle_strobe: got %b expected 0", ramREN);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) begin ramstate = ACCESS; ramload = 32'hDEADBEEF; end
      #1;
      checks++;
      if ({ramREN, ramWEN, ramaddr} !== {1'b1, 1'b0, 32'h40}) begin
        failures++; $display("FAIL fetch_strobe_c%0d: got %b %b %h expected 1 0 00000040", c, ramREN, ramWEN, ramaddr);
      end
      checks++;
      if (iwait !== ((c == 3) ? 2'b10 : 2'b11)) begin
        failures++; $display("FAIL fetch_iwait_c%0d: got %b expected %b", c, iwait, (c == 3) ? 2'b10 : 2'b11);
      end
      checks++;
      if (iload[0] !== ((c == 3) ? 32'hDEADBEEF : 32'h0)) begin
        failures++; $display("FAIL fetch_iload_c%0d: got %h expected %h", c, iload[0], (c == 3) ? 32'hDEADBEEF : 32'h0);
      end
    end
    tick();
    iREN = '0; ramstate = FREE;
    #1;
    checks++;
    if ({iwait, ramREN} !== 3'b110) begin
      failures++; $display("FAIL fetch_after: got %b expected 110", {iwait, ramREN});
    end
  endtask

  task automatic test_d_beats_i();
    dREN[0] = 1'b1; daddr[0] = 32'h100;
    iREN[0] = 1'b1; iaddr[0] = 32'h44;
    ramstate = ACCESS; ramload = 32'h11111111;
    tick();
    #1;
    checks++;
    if ({ramREN, ramaddr, dwait, iwait} !== {1'b1, 32'h100, 2'b10, 2'b11}) begin
      failures++; $display("FAIL dbi_first: got %b %h %b %b expected 1 00000100 10 11", ramREN, ramaddr, dwait, iwait);
    end
    checks++;
    if (dload[0] !== 32'h11111111) begin
      failures++; $display("FAIL dbi_dload: got %h expected 11111111", dload[0]);
    end
    tick();
    dREN = '0; ramload = 32'h22222222;
    #1;
    checks++;
    if ({ramREN, iwait, dwait} !== 5'b01111) begin
      failures++; $display("FAIL dbi_idle_gap: got %b expected 01111", {ramREN, iwait, dwait});
    end
    tick();
    #1;
    checks++;
    if ({ramREN, ramaddr, iwait, iload[0]} !== {1'b1, 32'h44, 2'b10, 32'h22222222}) begin
      failures++; $display("FAIL dbi_fetch: got %b %h %b %h expected 1 00000044 10 22222222", ramREN, ramaddr, iwait, iload[0]);
    end
    tick();
    iREN = '0; ramstate = FREE;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr, exp_data;
    logic [1:0]  exp_dwait;
    do_reset();
    dWEN = 2'b11;
    daddr[0] = 32'h200; daddr[1] = 32'h300;
    dstore[0] = 32'hA0; dstore[1] = 32'hB1;
    ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      tick();
      #1;
      exp_addr  = (k % 2 == 0) ? 32'h200 : 32'h300;
      exp_data  = (k % 2 == 0) ? 32'hA0 : 32'hB1;
      exp_dwait = (k % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({ramWEN, ramREN, ramaddr, ramstore} !== {1'b1, 1'b0, exp_addr, exp_data}) begin
        failures++; $display("FAIL rr_grant%0d: got %b %b %h %h expected 1 0 %h %h", k, ramWEN, ramREN, ramaddr, ramstore, exp_addr, exp_data);
      end
      checks++;
      if (dwait !== exp_dwait) begin
        failures++; $display("FAIL rr_dwait%0d: got %b expected %b", k, dwait, exp_dwait);
      end
      tick();
      if (k == 5) dWEN = '0;
      #1;
      checks++;
      if ({dwait, ramWEN} !== 3'b110) begin
        failures++; $display("FAIL rr_idle%0d: got %b expected 110", k, {dwait, ramWEN});
      end
    end
    ramstate = FREE;
  endtask

  task automatic test_error_retry();
    dREN[0] = 1'b1; daddr[0] = 32'h500; ramstate = ERROR;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin ramstate = ACCESS; ramload = 32'h55; end
      #1;
      checks++;
      if ({ramREN, ramaddr} !== {1'b1, 32'h500}) begin
        failures++; $display("FAIL err_strobe_c%0d: got %b %h expected 1 00000500", c, ramREN, ramaddr);
      end
      checks++;
      if ({dwait, iwait} !== ((c == 4) ? 4'b1011 : 4'b1111)) begin
        failures++; $display("FAIL err_wait_c%0d: got %b expected %b", c, {dwait, iwait}, (c == 4) ? 4'b1011 : 4'b1111);
      end
    end
    checks++;
    if (dload[0] !== 32'h55) begin
      failures++; $display("FAIL err_dload: got %h expected 00000055", dload[0]);
    end
    tick();
    dREN = '0;
    #1;
    checks++;
    if ({dwait, ramREN} !== 3'b110) begin
      failures++; $display("FAIL err_after: got %b expected 110", {dwait, ramREN});
    end
  endtask

  task automatic test_abort();
    iREN[1] = 1'b1; iaddr[1] = 32'h600;
    dREN[0] = 1'b1; daddr[0] = 32'h700;
    ramstate = BUSY; ramload = 32'h77;
    tick();
    #1;
    checks++;
    if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h600, 2'b11}) begin
      failures++; $display("FAIL abort_grant: got %b %h %b expected 1 00000600 11", ramREN, ramaddr, iwait);
    end
    iREN[1] = 1'b0;
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait} !== 6'b001111) begin
      failures++; $display("FAIL abort_drop: got %b expected 001111", {ramREN, ramWEN, iwait, dwait});
    end
    tick();
    ramstate = ACCESS;
    #1;
    checks++;
    if ({ramREN, iwait, dwait} !== 5'b01111) begin
      failures++; $display("FAIL abort_idle: got %b expected 01111", {ramREN, iwait, dwait});
    end
    checks++;
    if (dut.rr_ptr !== 1'b1) begin
      failures++; $display("FAIL abort_rr_ptr: got %0d expected 1", dut.rr_ptr);
    end
    tick();
    #1;
    checks++;
    if ({ramREN, ramaddr, dwait, iwait, dload[0]} !== {1'b1, 32'h700, 2'b10, 2'b11, 32'h77}) begin
      failures++; $display("FAIL abort_next: got %b %h %b %b %h expected 1 00000700 10 11 00000077", ramREN, ramaddr, dwait, iwait, dload[0]);
    end
    tick();
    dREN = '0; ramstate = FREE;
    #1;
  endtask

  task automatic test_reset_mid_serve();
    dWEN[0] = 1'b1; daddr[0] = 32'h800; dstore[0] = 32'h88; ramstate = BUSY;
    tick();
    #1;
    checks++;
    if ({ramWEN, ramaddr, ramstore} !== {1'b1, 32'h800, 32'h88}) begin
      failures++; $display("FAIL rst_pre: got %b %h %h expected 1 00000800 00000088", ramWEN, ramaddr, ramstore);
    end
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if ({ramREN, ramWEN, iwait, dwait, ramaddr} !== {2'b00, 4'b1111, 32'h0}) begin
      failures++; $display("FAIL rst_async: got %b %b %b %b %h expected 0 0 11 11 0", ramREN, ramWEN, iwait, dwait, ramaddr);
    end
    clear_inputs();
    #1;
    nRST = 1'b1;
    tick();
    #1;
    checks++;
    if (dut.rr_ptr !== 1'b0) begin
      failures++; $display("FAIL rst_rr_ptr: got %0d expected 0", dut.rr_ptr);
    end
    checks++;
    if ({ramREN, ramWEN, dwait} !== 4'b0011) begin
      failures++; $display("FAIL rst_idle: got %b expected 0011", {ramREN, ramWEN, dwait});
    end
    iREN = 2'b11; iaddr[0] = 32'h900; iaddr[1] = 32'hA00; ramstate = ACCESS;
    tick();
    #1;
    checks++;
    if ({ramaddr, iwait} !== {32'h900, 2'b10}) begin
      failures++; $display("FAIL rst_first_grant: got %h %b expected 00000900 10", ramaddr, iwait);
    end
    tick();
    iREN = '0;
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_d_beats_i();
    test_round_robin();
    test_error_retry();
    test_abort();
    test_reset_mid_serve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
